// File: rtl/delay_pipe_pkg.sv
// Shared constants and helpers for the delay_pipe register pipeline.
package delay_pipe_pkg;

  localparam int DEFAULT_WIDTH = 1;
  localparam int DEFAULT_DEPTH = 2;

  // Bits needed to count 0..depth valid stages.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/delay_pipe_stage.sv
// One pipeline stage: data register, valid flag and ready term of the ready chain.
// Optional DELAY_PIPE_FLUSH_EN adds a synchronous clear of the valid flag.
module delay_pipe_stage
  import delay_pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
`ifdef DELAY_PIPE_FLUSH_EN
  input  logic             flush_i,
`endif
  input  logic             src_valid_i,
  input  logic [WIDTH-1:0] src_data_i,
  input  logic             next_ready_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // An empty stage always takes its source, so bubbles collapse under stall.
  assign ready_o = !valid_q | next_ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (ready_o) begin
      valid_d = src_valid_i;
      if (src_valid_i) data_d = src_data_i;
    end
`ifdef DELAY_PIPE_FLUSH_EN
    if (flush_i) begin
      valid_d = 1'b0;
      data_d  = data_q;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/delay_pipe.sv
// DEPTH-stage valid/ready register pipeline with a combinational ready chain.
// Define DELAY_PIPE_FLUSH_EN to add the synchronous flush input.
module delay_pipe
  import delay_pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
`ifdef DELAY_PIPE_FLUSH_EN
  input  logic                       flush,
`endif
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [occ_width(DEPTH)-1:0] occupancy
);

  localparam int OCC_W = occ_width(DEPTH);

  // Handshake: a word moves across an interface on a rising edge where both
  // valid and ready are high; valid never depends on ready, ready may depend on valid.
  logic             accept_w, deliver_w;
  logic [OCC_W-1:0] occ_q, occ_d;

  for (genvar k = 0; k < DEPTH; k++) begin : gen_stage
    logic             src_valid_w, next_ready_w, ready_w, valid_w;
    logic [WIDTH-1:0] src_data_w, data_w;

    if (k == 0) begin : g_head
      assign src_valid_w = in_valid;
      assign src_data_w  = in_data;
    end else begin : g_body
      assign src_valid_w = gen_stage[k-1].valid_w;
      assign src_data_w  = gen_stage[k-1].data_w;
    end

    if (k == DEPTH - 1) begin : g_tail
      assign next_ready_w = out_ready;
    end else begin : g_link
      assign next_ready_w = gen_stage[k+1].ready_w;
    end

    delay_pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk_i        (clk),
      .rst_ni       (rst_n),
`ifdef DELAY_PIPE_FLUSH_EN
      .flush_i      (flush),
`endif
      .src_valid_i  (src_valid_w),
      .src_data_i   (src_data_w),
      .next_ready_i (next_ready_w),
      .ready_o      (ready_w),
      .valid_o      (valid_w),
      .data_o       (data_w)
    );
  end

`ifdef DELAY_PIPE_FLUSH_EN
  assign in_ready = gen_stage[0].ready_w & ~flush;
`else
  assign in_ready = gen_stage[0].ready_w;
`endif

  assign out_valid = gen_stage[DEPTH-1].valid_w;
  assign out_data  = gen_stage[DEPTH-1].data_w;

  assign accept_w  = in_valid & in_ready;
  assign deliver_w = out_valid & out_ready;

  always_comb begin
    occ_d = occ_q;
    case ({accept_w, deliver_w})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
`ifdef DELAY_PIPE_FLUSH_EN
    if (flush) occ_d = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) occ_q <= '0;
    else        occ_q <= occ_d;
  end

  assign occupancy = occ_q;

endmodule
